// File: rtl/vrf_pkg.sv
// Shared encodings, sizes and the byte-merge helper for the writeback register file.
package vrf_pkg;

   localparam int NREG = 32;
   localparam int DW   = 64;

   typedef enum logic [2:0] {
      PPP_ALL   = 3'b000,
      PPP_UPPER = 3'b001,
      PPP_LOWER = 3'b010,
      PPP_EVEN  = 3'b011,
      PPP_ODD   = 3'b100
   } ppp_e;

   typedef enum logic [1:0] {
      WIDTH_8  = 2'b00,
      WIDTH_16 = 2'b01,
      WIDTH_32 = 2'b10,
      WIDTH_64 = 2'b11
   } width_e;

   // Byte 0 is the MSB byte, bits [0:7].
   function automatic logic [0:DW-1] byte_merge(input logic [0:DW-1] old_v,
                                                input logic [0:DW-1] new_v,
                                                input logic [0:DW/8-1] mask);
      logic [0:DW-1] res;
      res = old_v;
      for (int b = 0; b < DW/8; b++) begin
         if (mask[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/ppp_mask_gen.sv
// Combinational PPP/width decode into a per-byte write mask plus an illegal-code flag.
module ppp_mask_gen
   import vrf_pkg::*;
(
   input  logic [0:2] wr_ppp,
   input  logic [0:1] wr_ww,
   output logic [0:7] byte_mask,
   output logic       illegal
);

   logic [0:7] even_mask;

   // Element 0 sits at the MSB end, so even elements always include byte 0.
   always_comb begin
      even_mask = 8'b1111_1111;
      case (wr_ww)
         WIDTH_8:  even_mask = 8'b1010_1010;
         WIDTH_16: even_mask = 8'b1100_1100;
         WIDTH_32: even_mask = 8'b1111_0000;
         WIDTH_64: even_mask = 8'b1111_1111;
         default:  even_mask = 8'b1111_1111;
      endcase
   end

   always_comb begin
      byte_mask = 8'b0000_0000;
      illegal   = 1'b0;
      case (wr_ppp)
         PPP_ALL:   byte_mask = 8'b1111_1111;
         PPP_UPPER: byte_mask = 8'b1111_0000;
         PPP_LOWER: byte_mask = 8'b0000_1111;
         PPP_EVEN:  byte_mask = even_mask;
         PPP_ODD:   byte_mask = ~even_mask;
         default:   illegal   = 1'b1;
      endcase
   end

endmodule

// File: rtl/vrf_wb.sv
// Writeback vector register file: 32x64b, PPP-masked byte writes, two registered read ports.
// VRF_BYPASS_EN: same-edge read of the written register returns merged data (else old data).
module vrf_wb
   import vrf_pkg::*;
#(
   parameter int NREG = vrf_pkg::NREG,
   parameter int DW   = vrf_pkg::DW
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    rd_en,
   input  logic [$clog2(NREG)-1:0] rA_addr,
   input  logic [$clog2(NREG)-1:0] rB_addr,
   output logic [0:DW-1]           rA_64bit_val,
   output logic [0:DW-1]           rB_64bit_val,
   output logic                    rd_valid,
   input  logic                    wr_en,
   input  logic [$clog2(NREG)-1:0] wr_addr,
   input  logic [0:DW-1]           wr_data,
   input  logic [0:2]              wr_ppp,
   input  logic [0:1]              wr_ww,
   output logic                    wr_err
);

   logic [0:DW-1]   regs_q [NREG];
   logic [0:DW-1]   ra_q, ra_d;
   logic [0:DW-1]   rb_q, rb_d;
   logic            rd_valid_q;
   logic            wr_err_q;
   logic [0:DW/8-1] byte_mask;
   logic            ppp_illegal;
   logic            wr_commit;
   logic [0:DW-1]   wr_merged;

   ppp_mask_gen u_mask (
      .wr_ppp    (wr_ppp),
      .wr_ww     (wr_ww),
      .byte_mask (byte_mask),
      .illegal   (ppp_illegal)
   );

   assign wr_commit = wr_en & ~ppp_illegal;
   assign wr_merged = byte_merge(regs_q[wr_addr], wr_data, byte_mask);

   always_comb begin
      ra_d = ra_q;
      rb_d = rb_q;
      if (rd_en) begin
         ra_d = regs_q[rA_addr];
         rb_d = regs_q[rB_addr];
`ifdef VRF_BYPASS_EN
         if (wr_commit && (wr_addr == rA_addr)) ra_d = wr_merged;
         if (wr_commit && (wr_addr == rB_addr)) rb_d = wr_merged;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
         ra_q       <= '0;
         rb_q       <= '0;
         rd_valid_q <= 1'b0;
         wr_err_q   <= 1'b0;
      end else begin
         if (wr_commit) regs_q[wr_addr] <= wr_merged;
         ra_q       <= ra_d;
         rb_q       <= rb_d;
         rd_valid_q <= rd_en;
         wr_err_q   <= wr_en & ppp_illegal;
      end
   end

   assign rA_64bit_val = ra_q;
   assign rB_64bit_val = rb_q;
   assign rd_valid     = rd_valid_q;
   assign wr_err       = wr_err_q;

endmodule

// File: tb/tb_vrf_wb.sv
// Randomized bench for vrf_wb against a byte-level reference model of the register file.
module tb_vrf_wb;

   logic        clk = 1'b0;
   logic        reset;
   logic        rd_en;
   logic [4:0]  rA_addr, rB_addr, wr_addr;
   logic [0:63] rA_64bit_val, rB_64bit_val;
   logic        rd_valid;
   logic        wr_en;
   logic [0:63] wr_data;
   logic [0:2]  wr_ppp;
   logic [0:1]  wr_ww;
   logic        wr_err;

   always #5 clk = ~clk;

   vrf_wb dut (
      .clk          (clk),
      .reset        (reset),
      .rd_en        (rd_en),
      .rA_addr      (rA_addr),
      .rB_addr      (rB_addr),
      .rA_64bit_val (rA_64bit_val),
      .rB_64bit_val (rB_64bit_val),
      .rd_valid     (rd_valid),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .wr_ppp       (wr_ppp),
      .wr_ww        (wr_ww),
      .wr_err       (wr_err)
   );

   int          n_chk = 0;
   int          n_bad = 0;
   logic [63:0] mdl_reg [32];
   logic [63:0] exp_a = '0;
   logic [63:0] exp_b = '0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // m[b] refers to byte b, byte 0 being the most significant.
   function automatic logic [7:0] ref_mask(input int ppp, input int ww, output bit bad);
      int          wbytes;
      int          elem;
      logic [7:0]  m;
      wbytes = 1 << ww;
      m      = '0;
      bad    = 1'b0;
      for (int b = 0; b < 8; b++) begin
         elem = b / wbytes;
         case (ppp)
            0:       m[b] = 1'b1;
            1:       m[b] = (b < 4);
            2:       m[b] = (b >= 4);
            3:       m[b] = (elem % 2 == 0);
            4:       m[b] = (elem % 2 == 1);
            default: bad  = 1'b1;
         endcase
      end
      return m;
   endfunction

   function automatic logic [63:0] ref_merge(input logic [63:0] old_v, input logic [63:0] new_v,
                                             input logic [7:0] m);
      logic [63:0] r;
      r = old_v;
      for (int b = 0; b < 8; b++)
         if (m[b]) r[63-8*b -: 8] = new_v[63-8*b -: 8];
      return r;
   endfunction

   task automatic cycle(input bit rst, input bit rd, input int ra, input int rb,
                        input bit we, input int wa, input logic [63:0] wd,
                        input int ppp, input int ww);
      bit          ill;
      logic [7:0]  m;
      logic [63:0] nv;
      bit          exp_v;
      bit          exp_e;
      m       = ref_mask(ppp, ww, ill);
      reset   = rst;
      rd_en   = rd;
      rA_addr = 5'(ra);
      rB_addr = 5'(rb);
      wr_en   = we;
      wr_addr = 5'(wa);
      wr_data = wd;
      wr_ppp  = 3'(ppp);
      wr_ww   = 2'(ww);
      if (rst) begin
         for (int i = 0; i < 32; i++) mdl_reg[i] = '0;
         exp_a = '0;
         exp_b = '0;
         exp_v = 1'b0;
         exp_e = 1'b0;
      end else begin
         nv = ref_merge(mdl_reg[wa], wd, m);
         if (rd) begin
            exp_a = mdl_reg[ra];
            exp_b = mdl_reg[rb];
`ifdef VRF_BYPASS_EN
            if (we && !ill && wa == ra) exp_a = nv;
            if (we && !ill && wa == rb) exp_b = nv;
`endif
         end
         exp_v = rd;
         exp_e = we && ill;
         if (we && !ill) mdl_reg[wa] = nv;
      end
      @(posedge clk);
      #1;
      check_val("rd_valid", 64'(rd_valid), 64'(exp_v));
      check_val("wr_err", 64'(wr_err), 64'(exp_e));
      check_val("rA_val", rA_64bit_val, exp_a);
      check_val("rB_val", rB_64bit_val, exp_b);
   endtask

   initial begin
      cycle(1, 0, 0, 0, 0, 0, '0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0, '0, 0, 0);

      cycle(0, 1, 0, 31, 0, 0, '0, 0, 0);
      check_val("plan_r0", rA_64bit_val, 64'h0);
      check_val("plan_r31", rB_64bit_val, 64'h0);
      check_val("plan_vld", 64'(rd_valid), 64'd1);

      cycle(0, 0, 0, 0, 1, 5, 64'h0123456789ABCDEF, 0, 0);
      cycle(0, 1, 5, 5, 0, 0, '0, 0, 0);
      check_val("plan_r5_all", rA_64bit_val, 64'h0123456789ABCDEF);
      cycle(0, 0, 0, 0, 1, 5, 64'hFFFFFFFFFFFFFFFF, 3, 0);
      cycle(0, 1, 5, 0, 0, 0, '0, 0, 0);
      check_val("plan_r5_even8", rA_64bit_val, 64'hFF23FF67FFABFFEF);
      cycle(0, 0, 0, 0, 1, 5, 64'h0, 2, 0);
      cycle(0, 1, 5, 0, 0, 0, '0, 0, 0);
      check_val("plan_r5_lower", rA_64bit_val, 64'hFF23FF6700000000);

      cycle(0, 0, 0, 0, 1, 7, 64'h0, 0, 0);
      cycle(0, 0, 0, 0, 1, 7, 64'hAAAABBBBCCCCDDDD, 4, 1);
      cycle(0, 1, 7, 0, 0, 0, '0, 0, 0);
      check_val("plan_r7_odd16", rA_64bit_val, 64'h0000BBBB0000DDDD);
      cycle(0, 0, 0, 0, 1, 7, 64'h1234123412341234, 5, 1);
      check_val("plan_err_pulse", 64'(wr_err), 64'd1);
      cycle(0, 1, 0, 7, 0, 0, '0, 0, 0);
      check_val("plan_err_clear", 64'(wr_err), 64'd0);
      check_val("plan_r7_kept", rB_64bit_val, 64'h0000BBBB0000DDDD);

      cycle(0, 0, 0, 0, 1, 3, 64'h22, 0, 0);
      cycle(0, 1, 3, 3, 1, 3, 64'h11, 0, 0);
`ifdef VRF_BYPASS_EN
      check_val("plan_r3_same_edge", rA_64bit_val, 64'h11);
`else
      check_val("plan_r3_same_edge", rA_64bit_val, 64'h22);
`endif
      cycle(0, 1, 3, 3, 0, 0, '0, 0, 0);
      check_val("plan_r3_after", rB_64bit_val, 64'h11);

      cycle(0, 0, 0, 0, 1, 9, 64'h77, 0, 0);
      cycle(1, 1, 9, 9, 1, 9, 64'h55, 0, 0);
      check_val("plan_rst_outA", rA_64bit_val, 64'h0);
      check_val("plan_rst_vld", 64'(rd_valid), 64'd0);
      cycle(0, 1, 9, 5, 0, 0, '0, 0, 0);
      check_val("plan_r9_cleared", rA_64bit_val, 64'h0);
      check_val("plan_r5_cleared", rB_64bit_val, 64'h0);

      for (int i = 0; i < 600; i++) begin
         cycle(($urandom_range(0, 59) == 0),
               $urandom_range(0, 1),
               $urandom_range(0, 7), $urandom_range(0, 7),
               ($urandom_range(0, 3) != 0),
               $urandom_range(0, 7),
               {$urandom, $urandom},
               $urandom_range(0, 7), $urandom_range(0, 3));
      end
      cycle(0, 1, 31, 30, 1, 31, 64'hDEADBEEFCAFEF00D, 0, 3);
      cycle(0, 1, 31, 0, 0, 0, '0, 0, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/vrf_wb.md
# vrf_wb

Writeback-side vector register file for the 64-bit SIMD datapath. It stores 32 × 64-bit registers, accepts ALU results with partial-field (PPP) write masking, and serves the two registered operand read ports that drive the ALU's `rA_64bit_val`/`rB_64bit_val` inputs. Bit 0 is the MSB throughout (`[0:63]` ordering). It is the producer end of the ALU operand interface and the consumer of `ALU_out`.

## Interface
Parameters:
- `NREG`, 32: number of registers. Must be a power of 2.
- `DW`, 64: register width. Fixed at 64; other values are unsupported.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `rd_en`  in  1: sample the read addresses this cycle.
- `rA_addr`, `rB_addr`  in  5 each: read addresses.
- `rA_64bit_val`, `rB_64bit_val`  out  [0:63] each: registered read data, sent to the ALU.
- `rd_valid`  out  1: read data is valid this cycle.
- `wr_en`  in  1: write request.
- `wr_addr`  in  5: destination register.
- `wr_data`  in  [0:63]: result from `ALU_out`.
- `wr_ppp`  in  [0:2]: participation field.
- `wr_ww`  in  [0:1]: element width. 00 = 8, 01 = 16, 10 = 32, 11 = 64 bits.
- `wr_err`  out  1: one-cycle pulse on a write with an illegal PPP code.

## Operation
- PPP byte mask. Bytes 0..7 map to bits [0:7]..[56:63].
  - 000: all bytes.
  - 001: upper half, bytes 0–3.
  - 010: lower half, bytes 4–7.
  - 011: even-indexed elements of width WW.
  - 100: odd-indexed elements of width WW.
  - 101/110/111: illegal. Nothing is written and `wr_err` pulses.
- Element numbering starts at 0 at the MSB. Examples:
  - WW=00: even elements are bytes 0, 2, 4, 6.
  - WW=01: even elements are halfwords 0 and 2, i.e. bytes 0–1 and 4–5.
  - WW=10: even = bytes 0–3, odd = bytes 4–7.
  - WW=11 with 011: the full register is written.
  - WW=11 with 100: nothing is written, and `wr_err` does not pulse.
- Write: on an edge with `wr_en`=1, each masked byte of `reg[wr_addr]` takes the corresponding byte of `wr_data`. Unmasked bytes hold their value.
- Read: on an edge with `rd_en`=1, both read outputs load `reg[addr]`. `rd_valid` is `rd_en` delayed by one cycle. When `rd_en`=0, the outputs hold their last value.
- `rA_addr` == `rB_addr` is legal; both ports return identical data.
- Simultaneous read and write to the same address: see `VRF_BYPASS_EN` under Configuration.
- Register 0 is an ordinary, writable register.

## Timing
- Read latency is 1 cycle: address at edge N, data and `rd_valid` after edge N.
- Write latency is 1 cycle: the new value is visible to a read sampled at edge N+1 or later.
- Reset:
  - All 32 registers are 0.
  - `rA_64bit_val` and `rB_64bit_val` are 0.
  - `rd_valid` and `wr_err` are 0.
- Reset has priority over `wr_en` and `rd_en` on the same edge. A write or read issued in the reset cycle is dropped.
- `wr_err` is asserted for exactly the cycle after the offending write edge.
- There is no backpressure. One write and one dual read are accepted every cycle.

## Configuration
- `VRF_BYPASS_EN` defined:
  - A read whose address equals `wr_addr` while `wr_en`=1 on the same edge returns the merged value: new bytes where the mask is set, old bytes elsewhere.
  - Illegal PPP bypasses nothing.
- `VRF_BYPASS_EN` undefined:
  - The same read returns the pre-write (old) value, i.e. read-before-write.
  - The pipeline inserts one stall cycle for this case.

## Structure
- Package `vrf_pkg`:
  - PPP encodings `PPP_ALL`, `PPP_UPPER`, `PPP_LOWER`, `PPP_EVEN`, `PPP_ODD`.
  - Width encodings `WIDTH_8`, `WIDTH_16`, `WIDTH_32`, `WIDTH_64`.
  - `NREG` and `DW` constants.
- Sub-module `ppp_mask_gen`:
  - Purely combinational.
  - Inputs `wr_ppp` and `wr_ww`; outputs an 8-bit byte mask `[0:7]` and an `illegal` flag.
  - Shared by the write logic and the bypass merge.

## Test plan
- Reset, then read r0 and r31 → both outputs 0; `rd_valid` is 1 one cycle after `rd_en`.
- Write r5 = 0x0123456789ABCDEF with PPP=000, read next cycle → 0x0123456789ABCDEF.
- r5 preloaded as above, write 0xFFFFFFFFFFFFFFFF with PPP=011, WW=00 → r5 = 0xFF23FF67FFABFFEF. Then PPP=010 with data 0 → 0xFF23FF6700000000.
- r7 = 0, write 0xAAAABBBBCCCCDDDD with PPP=100, WW=01 → r7 = 0x0000BBBB0000DDDD. PPP=101 → r7 unchanged and `wr_err` pulses once.
- Same-edge write of r3 = 0x11 (PPP=000, r3 previously 0x22) with read of r3:
  - bypass build → 0x11.
  - non-bypass build → 0x22, then 0x11 on the next read.
- Assert `reset` the same cycle as a write to r9 = 0x55 → r9 reads 0 afterwards, and all outputs are 0 the cycle after reset.
